// File: rtl/capture_pkg.sv
// Shared types and parameter defaults for the acquisition sequencer.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        DONE      = 2'd3
    } cap_state_t;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DEC_W_DEF  = 4;

endpackage

// File: rtl/smpl_strobe_gen.sv
// Decimated sample strobe: one pulse every 2^dec cycles while run is high.
module smpl_strobe_gen
    import capture_pkg::*;
#(
    parameter int unsigned DEC_W = DEC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [DEC_W-1:0] dec,
    output logic             smpl_en
);

    localparam int unsigned      CNT_W = 2 ** DEC_W;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [DEC_W-1:0] dec_l;
    logic [CNT_W-1:0] dec_cnt;
    logic [CNT_W-1:0] term;
    logic             at_term;

    always_comb begin
        term    = (ONE << dec_l) - ONE;
        at_term = (dec_cnt == term);
        // clr restarts the period, so the old exponent must not strobe that cycle
        smpl_en = run & ~clr & at_term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
            dec_l   <= '0;
        end else if (clr) begin
            dec_cnt <= '0;
            dec_l   <= dec;
        end else if (run) begin
            if (at_term) begin
                dec_cnt <= '0;
            end else begin
                dec_cnt <= dec_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: pre-trigger fill, trigger qualification,
// post-trigger count and circular sample RAM addressing.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEC_W  = DEC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              stop,
    input  logic [DEC_W-1:0]  decimator,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              trig_event,
    output logic              smpl_en,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done
);

    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   P_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   PRE_FULL = {1'b1, {ADDR_W{1'b0}}};

    cap_state_t        state;
    cap_state_t        state_nxt;
    logic [ADDR_W-1:0] trig_pos_l;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W:0]   pre_cnt;
    logic              active;
    logic              run;
    logic              strobe;
    logic              pre_ok;
    logic              qual;
    logic              post_last;

    assign active = (state == ARMED) || (state == TRIGGERED);
    // stop and rst suppress the write in their own cycle so waddr really holds
    assign run    = active & ~stop & ~rst;

    smpl_strobe_gen #(
        .DEC_W (DEC_W)
    ) u_strobe (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .clr     (arm),
        .dec     (decimator),
        .smpl_en (strobe)
    );

    // DEPTH-1-trig_pos_l is the bitwise inverse of trig_pos_l at ADDR_W bits
    always_comb begin
        pre_ok    = (pre_cnt >= {1'b0, ~trig_pos_l});
        qual      = (state == ARMED) & strobe & trig_event & pre_ok;
        post_last = (state == TRIGGERED) & strobe & (post_cnt == (trig_pos_l - A_ONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = ARMED;
        end else if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ARMED: begin
                    if (qual) begin
                        state_nxt = (trig_pos_l == '0) ? DONE : TRIGGERED;
                    end
                end
                TRIGGERED: begin
                    if (post_last) begin
                        state_nxt = DONE;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_comb begin
        smpl_en      = strobe;
        we           = strobe;
        armed        = active;
        triggered    = (state == TRIGGERED) || (state == DONE);
        capture_done = (state == DONE);
    end

    // trig_pos is ADDR_W bits wide, so it can never exceed DEPTH-1 and latches as-is
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr      <= '0;
            trig_addr  <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            trig_pos_l <= '0;
        end else if (arm) begin
            waddr      <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            trig_pos_l <= trig_pos;
        end else if (strobe) begin
            waddr <= waddr + A_ONE;
            if ((state == ARMED) && (pre_cnt != PRE_FULL)) begin
                pre_cnt <= pre_cnt + P_ONE;
            end
            if (qual) begin
                trig_addr <= waddr;
                post_cnt  <= '0;
            end else if (state == TRIGGERED) begin
                post_cnt <= post_cnt + A_ONE;
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized scoreboard bench for capture_ctrl against an acquisition-level model.
module tb_capture_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 4;
    localparam int          DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, arm, stop, trig_event;
    logic [DW-1:0] decimator;
    logic [AW-1:0] trig_pos;
    logic          smpl_en, we, armed, triggered, capture_done;
    logic [AW-1:0] waddr, trig_addr;

    always #5 clk = ~clk;

    capture_ctrl #(.ADDR_W(AW), .DEC_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .stop         (stop),
        .decimator    (decimator),
        .trig_pos     (trig_pos),
        .trig_event   (trig_event),
        .smpl_en      (smpl_en),
        .we           (we),
        .waddr        (waddr),
        .trig_addr    (trig_addr),
        .armed        (armed),
        .triggered    (triggered),
        .capture_done (capture_done)
    );

    typedef struct {
        bit we;
        bit armed;
        bit trg;
        bit dn;
        int waddr;
        int taddr;
    } exp_t;

    exp_t fq[$];
    int   wq[$];
    int   total = 0;
    int   bad   = 0;

    // acquisition-level model: write k after arm lands at cycle k*2^dec, address k mod DEPTH
    bit m_act = 0, m_trg = 0, m_done = 0;
    int m_n = 0, m_tp = 0, m_per = 1, m_cyc = 0, m_left = 0, m_taddr = 0;
    int cur_d = 0, cur_tp = 0;

    task chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit a, input bit s, input bit t,
                        input int d, input int tp);
        exp_t e;
        bit   w;
        int   filled;
        @(posedge clk);
        #1;
        rst        = r;
        arm        = a;
        stop       = s;
        trig_event = t;
        decimator  = d[DW-1:0];
        trig_pos   = tp[AW-1:0];

        e.armed = m_act;
        e.trg   = m_trg;
        e.dn    = m_done;
        e.waddr = m_n % DEPTH;
        e.taddr = m_taddr;
        w       = m_act && !r && !a && !s && ((m_cyc % m_per) == 0);
        e.we    = w;
        fq.push_back(e);

        if (w) begin
            wq.push_back(m_n % DEPTH);
            filled = (m_n < DEPTH) ? m_n : DEPTH;
            if (!m_trg) begin
                if (t && (filled >= DEPTH - 1 - m_tp)) begin
                    m_trg   = 1;
                    m_taddr = m_n % DEPTH;
                    m_left  = m_tp;
                end
            end else begin
                m_left--;
            end
            m_n++;
        end

        if (r) begin
            m_act = 0; m_trg = 0; m_done = 0; m_n = 0; m_taddr = 0;
            m_cyc = 0; m_tp = 0; m_per = 1; m_left = 0;
        end else if (a) begin
            m_act = 1; m_trg = 0; m_done = 0; m_n = 0;
            m_tp = tp; m_per = 1 << d; m_cyc = 1; m_left = 0;
        end else if (s) begin
            m_act = 0; m_trg = 0; m_done = 0;
        end else begin
            if (m_act && m_trg && (m_left == 0)) begin
                m_act  = 0;
                m_done = 1;
            end
            m_cyc++;
        end
    endtask

    task automatic idle_n(input int n, input bit t);
        repeat (n) step(0, 0, 0, t, cur_d, cur_tp);
    endtask

    task automatic do_arm(input int d, input int tp, input bit t);
        cur_d  = d;
        cur_tp = tp;
        step(0, 1, 0, t, d, tp);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (fq.size() > 0) begin
            me = fq.pop_front();
            chk("we", we, me.we);
            chk("smpl_en", smpl_en, me.we);
            chk("armed", armed, me.armed);
            chk("triggered", triggered, me.trg);
            chk("capture_done", capture_done, me.dn);
            chk("waddr", waddr, me.waddr);
            chk("trig_addr", trig_addr, me.taddr);
        end
        if (we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("write_unexpected", 1, 0);
            end else begin
                chk("write_addr", waddr, wq.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; arm = 1'b0; stop = 1'b0; trig_event = 1'b0;
        decimator = '0; trig_pos = '0;

        repeat (3) step(1, 0, 0, 0, 0, 0);
        idle_n(3, 1);

        // dec=2, no trigger: strobe every 4 cycles, waddr wraps past 15
        do_arm(2, 4, 0);
        idle_n(80, 0);
        step(0, 0, 1, 0, cur_d, cur_tp);
        idle_n(3, 0);

        // trig_pos=4, trig_event held high from arm
        do_arm(1, 4, 1);
        idle_n(45, 1);

        // trig_pos=0, dec=0: trigger on the 16th write then DONE
        do_arm(0, 0, 1);
        idle_n(22, 1);

        // trig_pos=15: immediate qualification
        do_arm(0, 15, 1);
        idle_n(22, 1);

        // trig_event on non-strobe cycles only, then held
        do_arm(2, 15, 0);
        step(0, 0, 0, 1, cur_d, cur_tp);
        step(0, 0, 0, 1, cur_d, cur_tp);
        idle_n(6, 0);
        step(0, 0, 0, 1, cur_d, cur_tp);
        idle_n(8, 0);
        idle_n(70, 1);

        // mid-TRIGGERED rst, stop and re-arm
        do_arm(0, 10, 1);
        idle_n(9, 1);
        step(1, 0, 0, 1, cur_d, cur_tp);
        idle_n(3, 1);
        do_arm(0, 10, 1);
        idle_n(9, 1);
        step(0, 0, 1, 1, cur_d, cur_tp);
        idle_n(4, 1);
        do_arm(0, 10, 1);
        idle_n(9, 1);
        do_arm(1, 3, 1);
        idle_n(40, 1);
        step(0, 1, 1, 0, 0, 6);
        idle_n(20, 0);
        step(0, 0, 1, 0, 0, 0);
        idle_n(3, 0);

        // random traffic; decimator/trig_pos wiggle every cycle after arm
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2),
                 $urandom_range(0, 15));
        end

        idle_n(2, 0);
        @(negedge clk);
        #1;
        chk("expect_queue_drained", fq.size(), 0);
        chk("write_queue_drained", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
